// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared coordinate width, screen size and line FSM state type
package render_pkg;
  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    SENT,
    FINISH
  } line_state_t;
endpackage

// File: rtl/line_step_calc.sv
// rtl/line_step_calc.sv - one combinational Bresenham step (error update and point advance)
module line_step_calc #(
  parameter int W = 10
) (
  input  logic [W-1:0]        x,
  input  logic [W-1:0]        y,
  input  logic signed [W+1:0] err,
  input  logic signed [W+1:0] dx,
  input  logic signed [W+1:0] dy,
  input  logic signed [W+1:0] sx,
  input  logic signed [W+1:0] sy,
  output logic [W-1:0]        x_next,
  output logic [W-1:0]        y_next,
  output logic signed [W+1:0] err_next
);
  logic signed [W+2:0] e2;
  logic signed [W+2:0] dx_w;
  logic signed [W+2:0] dy_w;
  logic signed [W+1:0] x_sum;
  logic signed [W+1:0] y_sum;
  logic                step_x;
  logic                step_y;

  always_comb begin
    e2     = $signed({err, 1'b0});
    dx_w   = {dx[W+1], dx};
    dy_w   = {dy[W+1], dy};
    step_x = (e2 >= dy_w);
    step_y = (e2 <= dx_w);
    err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    // coordinates are unsigned; sx/sy of -1 wrap correctly after truncation
    x_sum  = $signed({2'b00, x}) + sx;
    y_sum  = $signed({2'b00, y}) + sy;
    x_next = step_x ? W'(x_sum) : x;
    y_next = step_y ? W'(y_sum) : y;
  end
endmodule

// File: rtl/line_drawer.sv
// rtl/line_drawer.sv - Bresenham line stepper emitting one pixel write per enable
// Optional macro LINE_CLIP_EN suppresses writes for points outside SCREEN_W x SCREEN_H.
module line_drawer
  import render_pkg::*;
#(
  parameter int COORD_W = render_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_new,
  input  logic               draw_enable,
  input  logic               enable,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_we,
  output logic               done,
  output logic               busy
);
  localparam logic signed [COORD_W+1:0] PLUS_ONE  = (COORD_W+2)'(1);
  localparam logic signed [COORD_W+1:0] MINUS_ONE = -(COORD_W+2)'(1);

  line_state_t state, state_next;
  logic [COORD_W-1:0] cur_x, cur_y, end_x, end_y;
  logic [COORD_W-1:0] cur_x_next, cur_y_next, end_x_next, end_y_next;
  logic [COORD_W-1:0] pix_x_next, pix_y_next;
  logic               pix_we_next, done_next;
  logic signed [COORD_W+1:0] dx, dy, sx, sy, err;
  logic signed [COORD_W+1:0] dx_next, dy_next, sx_next, sy_next, err_next;
  logic signed [COORD_W+1:0] diff_x, diff_y;
  logic [COORD_W-1:0]        step_x, step_y;
  logic signed [COORD_W+1:0] step_err;
  logic write_ok, at_end, on_screen;

  line_step_calc #(.W(COORD_W)) u_step (
    .x        (cur_x),
    .y        (cur_y),
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .sx       (sx),
    .sy       (sy),
    .x_next   (step_x),
    .y_next   (step_y),
    .err_next (step_err)
  );

  assign busy = (state != IDLE) && !done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cur_x  <= '0;
      cur_y  <= '0;
      end_x  <= '0;
      end_y  <= '0;
      dx     <= '0;
      dy     <= '0;
      sx     <= '0;
      sy     <= '0;
      err    <= '0;
      pix_x  <= '0;
      pix_y  <= '0;
      pix_we <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      cur_x  <= cur_x_next;
      cur_y  <= cur_y_next;
      end_x  <= end_x_next;
      end_y  <= end_y_next;
      dx     <= dx_next;
      dy     <= dy_next;
      sx     <= sx_next;
      sy     <= sy_next;
      err    <= err_next;
      pix_x  <= pix_x_next;
      pix_y  <= pix_y_next;
      pix_we <= pix_we_next;
      done   <= done_next;
    end
  end

  always_comb begin
    state_next  = state;
    cur_x_next  = cur_x;
    cur_y_next  = cur_y;
    end_x_next  = end_x;
    end_y_next  = end_y;
    dx_next     = dx;
    dy_next     = dy;
    sx_next     = sx;
    sy_next     = sy;
    err_next    = err;
    pix_x_next  = pix_x;
    pix_y_next  = pix_y;
    pix_we_next = 1'b0;
    done_next   = done;

    diff_x   = $signed({2'b00, x1}) - $signed({2'b00, x0});
    diff_y   = $signed({2'b00, y1}) - $signed({2'b00, y0});
    write_ok = enable && ((state == READY) || (state == SENT));
    at_end   = (cur_x == end_x) && (cur_y == end_y);
`ifdef LINE_CLIP_EN
    on_screen = (cur_x < COORD_W'(SCREEN_W)) && (cur_y < COORD_W'(SCREEN_H));
`else
    on_screen = 1'b1;
`endif

    if (set_new && draw_enable) begin
      cur_x_next = x0;
      cur_y_next = y0;
      end_x_next = x1;
      end_y_next = y1;
      dx_next    = diff_x[COORD_W+1] ? -diff_x : diff_x;
      dy_next    = diff_y[COORD_W+1] ? diff_y : -diff_y;
      sx_next    = (x0 < x1) ? PLUS_ONE : MINUS_ONE;
      sy_next    = (y0 < y1) ? PLUS_ONE : MINUS_ONE;
      err_next   = (diff_x[COORD_W+1] ? -diff_x : diff_x)
                 + (diff_y[COORD_W+1] ? diff_y : -diff_y);
      done_next  = 1'b0;
      state_next = READY;
    end else begin
      if (write_ok) begin
        pix_x_next  = cur_x;
        pix_y_next  = cur_y;
        pix_we_next = on_screen;
        state_next  = at_end ? FINISH : SENT;
        if (at_end) done_next = 1'b1;
      end
      // a step follows a write, either from an earlier cycle or this one
      if (draw_enable && ((state == SENT) || (write_ok && !at_end))) begin
        cur_x_next = step_x;
        cur_y_next = step_y;
        err_next   = step_err;
        state_next = READY;
      end
    end
  end
endmodule
